// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the combinational imem word into
// an IF/ID register with a valid/ready handshake, and traps illegal fetch targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic        id_valid_next;
  logic [31:0] id_instruction_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_pc_plus4_next;
  logic [31:0] fault_pc_next;
  logic        load;

  // A wrapped PC+4 lands near 0 only after passing LAST_PC, so it is trapped here first.
  function automatic logic legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_PC);
  endfunction

  assign load  = !id_valid || id_ready;
  assign fault = (state == S_FAULT);

  always_comb begin
    // NOTE: every next-value gets a hold default first so no path through the case infers a latch.
    state_next          = state;
    pc_next             = pc;
    id_valid_next       = id_valid;
    id_instruction_next = id_instruction;
    id_pc_next          = id_pc;
    id_pc_plus4_next    = id_pc_plus4;
    fault_pc_next       = fault_pc;

    unique case (state)
      S_BOOT: state_next = S_RUN;

      S_RUN: begin
        if (redirect_valid) begin
          id_valid_next = 1'b0;
          if (legal(redirect_pc)) begin
            pc_next = redirect_pc;
          end else begin
            state_next    = S_FAULT;
            fault_pc_next = redirect_pc;
          end
        end else if (load) begin
          if (!legal(pc)) begin
            state_next    = S_FAULT;
            fault_pc_next = pc;
            id_valid_next = 1'b0;
          end else begin
            id_instruction_next = instruction;
            id_pc_next          = pc;
            id_pc_plus4_next    = pc + 32'd4;
            id_valid_next       = 1'b1;
            pc_next             = pc + 32'd4;
          end
        end
      end

      S_FAULT: id_valid_next = 1'b0;

      default: state_next = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_BOOT;
      pc             <= RESET_PC;
      id_valid       <= 1'b0;
      id_instruction <= '0;
      id_pc          <= '0;
      id_pc_plus4    <= '0;
      fault_pc       <= '0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      id_valid       <= id_valid_next;
      id_instruction <= id_instruction_next;
      id_pc          <= id_pc_next;
      id_pc_plus4    <= id_pc_plus4_next;
      fault_pc       <= fault_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected IF/ID words is
// popped on every accepted handshake, and each scenario task checks its own state.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] imem[64];
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] W0 = 32'h0002_1025;
  localparam logic [31:0] W1 = 32'h00FF_2025;
  localparam logic [31:0] W2 = 32'h0000_0025;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (pc < 32'd256 && pc[1:0] == 2'b00) instruction = imem[pc[7:2]];
    else                                  instruction = 32'hDEAD_BEEF;
  end

  // A word shown with valid and ready at the negedge is delivered at the coming posedge.
  always @(negedge clk) begin
    if (reset && id_valid && id_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got id_pc=%h id_instruction=%h required=no delivery", id_pc, id_instruction);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({id_instruction, id_pc, id_pc_plus4} !== {e.instr, e.addr, e.addr + 32'd4}) begin
          failures++;
          $display("FAIL sb_word got instr=%h pc=%h pc4=%h required instr=%h pc=%h pc4=%h",
                   id_instruction, id_pc, id_pc_plus4, e.instr, e.addr, e.addr + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = imem[addr[7:2]];
    e.addr  = addr;
    sb.push_back(e);
  endtask

  task automatic test_reset(input string name);
    @(negedge clk);
    #1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    step();
    checks++;
    if ({pc, id_valid, id_instruction, id_pc, id_pc_plus4, fault, fault_pc} !== {32'h0, 1'b0, 96'h0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL %s got pc=%h v=%b instr=%h idpc=%h pc4=%h fault=%b fpc=%h required all zero",
               name, pc, id_valid, id_instruction, id_pc, id_pc_plus4, fault, fault_pc);
    end
  endtask

  task automatic test_stream();
    reset    = 1'b1;
    id_ready = 1'b1;
    push(32'h0); push(32'h4); push(32'h8);
    step();
    checks++;
    if ({id_valid, pc} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL boot_cycle got v=%b pc=%h required v=0 pc=0", id_valid, pc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({id_valid, id_pc, pc} !== {1'b1, 32'(4 * k), 32'(4 * k + 4)}) begin
        failures++;
        $display("FAIL stream_%0d got v=%b idpc=%h pc=%h required v=1 idpc=%h pc=%h",
                 k, id_valid, id_pc, pc, 32'(4 * k), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({id_valid, id_instruction, id_pc, pc} !== {1'b1, W0, 32'h0, 32'h4}) begin
        failures++;
        $display("FAIL stall_%0d got v=%b instr=%h idpc=%h pc=%h required v=1 instr=%h idpc=0 pc=4",
                 k, id_valid, id_instruction, id_pc, pc, W0);
      end
      if (k < 3) step();
    end
    push(32'h0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    checks++;
    if ({id_valid, id_instruction, id_pc, pc} !== {1'b1, W1, 32'h4, 32'h8}) begin
      failures++;
      $display("FAIL stall_release got v=%b instr=%h idpc=%h pc=%h required v=1 instr=%h idpc=4 pc=8",
               id_valid, id_instruction, id_pc, pc, W1);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    checks++;
    if ({id_valid, pc} !== {1'b0, 32'h8}) begin
      failures++;
      $display("FAIL redirect_bubble got v=%b pc=%h required v=0 pc=8", id_valid, pc);
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    push(32'h8);
    step();
    checks++;
    if ({id_valid, id_pc, id_instruction} !== {1'b1, 32'h8, W2}) begin
      failures++;
      $display("FAIL redirect_target got v=%b idpc=%h instr=%h required v=1 idpc=8 instr=%h",
               id_valid, id_pc, id_instruction, W2);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    checks++;
    if ({id_valid, pc} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL redirect_flush got v=%b pc=%h required v=0 pc=0", id_valid, pc);
    end
    redirect_valid = 1'b0;
    push(32'h0);
    step();
  endtask

  task automatic test_boundary();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFC;
    step();
    redirect_valid = 1'b0;
    push(32'hFC);
    step();
    checks++;
    if ({id_valid, id_pc_plus4, pc, fault} !== {1'b1, 32'h100, 32'h100, 1'b0}) begin
      failures++;
      $display("FAIL last_word got v=%b pc4=%h pc=%h fault=%b required v=1 pc4=100 pc=100 fault=0",
               id_valid, id_pc_plus4, pc, fault);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({fault, fault_pc, id_valid, pc} !== {1'b1, 32'h100, 1'b0, 32'h100}) begin
        failures++;
        $display("FAIL range_fault_%0d got fault=%b fpc=%h v=%b pc=%h required fault=1 fpc=100 v=0 pc=100",
                 k, fault, fault_pc, id_valid, pc);
      end
      redirect_valid = (k == 0);
      redirect_pc    = 32'h0;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    reset    = 1'b1;
    id_ready = 1'b1;
    push(32'h0);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({fault, fault_pc, id_valid, pc} !== {1'b1, 32'h6, 1'b0, 32'h4}) begin
      failures++;
      $display("FAIL misaligned got fault=%b fpc=%h v=%b pc=%h required fault=1 fpc=6 v=0 pc=4",
               fault, fault_pc, id_valid, pc);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({id_valid, id_pc, id_instruction, pc} !== {1'b1, 32'h10, imem[4], 32'h14}) begin
      failures++;
      $display("FAIL pre_reset got v=%b idpc=%h instr=%h pc=%h required v=1 idpc=10 instr=%h pc=14",
               id_valid, id_pc, id_instruction, pc, imem[4]);
    end
    test_reset("reset_mid_run");
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({id_valid, id_instruction, id_pc, pc} !== {1'b1, W0, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL resume_after_reset got v=%b instr=%h idpc=%h pc=%h required v=1 instr=%h idpc=0 pc=4",
               id_valid, id_instruction, id_pc, pc, W0);
    end
  endtask

  initial begin
    imem[0] = W0;
    imem[1] = W1;
    imem[2] = W2;
    for (int i = 3; i < 64; i++) imem[i] = {8'hA5, 16'(i), 8'h13};

    test_reset("reset_initial");
    test_stream();
    test_reset("reset_after_stream");
    test_stall();
    test_redirect();
    test_boundary();
    test_reset("reset_in_fault");
    test_misaligned();
    test_reset("reset_after_misaligned");
    test_mid_reset();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. It owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into an IF/ID register with a valid/ready handshake toward decode. It also accepts branch/jump redirects from execute and traps out-of-range or misaligned fetch addresses into a sticky fault state.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
- IMEM_BYTES, 256, instruction memory size in bytes; a legal fetch address satisfies pc <= IMEM_BYTES-4

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk)
- pc  output  32  current fetch byte address to instruction memory
- instruction  input  32  word returned combinationally for pc, same cycle
- redirect_valid  input  1  execute requests PC change this cycle
- redirect_pc  input  32  redirect target byte address
- id_valid  output  1  IF/ID register holds a valid instruction
- id_ready  input  1  decode accepts IF/ID contents this cycle
- id_instruction  output  32  captured instruction word
- id_pc  output  32  address the word was fetched from
- id_pc_plus4  output  32  id_pc + 4 (mod 2^32), for JAL/JALR link
- fault  output  1  sticky fetch fault
- fault_pc  output  32  offending address

## Operation

- States: BOOT, RUN, FAULT.
- Reset (reset==0 at posedge): state=BOOT, pc=RESET_PC; id_valid=0, id_instruction=0, id_pc=0, id_pc_plus4=0, fault=0, fault_pc=0. Reset overrides everything, including mid-operation and FAULT.
- BOOT: one cycle, no capture, ignores redirect; -> RUN. Gives instruction memory a settled cycle after reset.
- RUN, load condition L = !id_valid || id_ready. Priority per cycle:
  1. redirect_valid=1 (independent of L): id_valid<=0 (flush; a same-cycle handshake still counts as delivered). If redirect_pc[1:0]==0 and redirect_pc <= IMEM_BYTES-4: pc<=redirect_pc. Else: -> FAULT, fault_pc<=redirect_pc.
  2. L=1 and pc illegal (pc[1:0]!=0 or pc > IMEM_BYTES-4): -> FAULT, fault_pc<=pc, id_valid<=0.
  3. L=1: id_instruction<=instruction, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
  4. L=0: hold pc and all id_* outputs stable.
- FAULT: fault=1, id_valid=0, pc held; redirect and id_ready ignored; exit only via reset.
- Arithmetic: all PC adds are 32-bit, wrap mod 2^32 (wrap is caught by range check before any fetch).
- id_* outputs must not change while id_valid=1 and id_ready=0, except flush by redirect.

## Timing

- pc is a registered output; instruction sampled in the same cycle it is presented.
- Edge E0 = first posedge with reset=1: BOOT->RUN. E1: word at RESET_PC captured, id_valid=1, pc=RESET_PC+4.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction/cycle with id_ready held 1.
- Redirect penalty: 1 bubble cycle (id_valid=0 for one cycle after the redirect edge; target word valid at the following edge).
- fault and fault_pc update on the edge the fault is detected; fault remains 1 until reset.

## Test plan

- Memory bytes 00 02 10 25 / 00 FF 20 25 / 00 00 00 25 at 0/4/8, id_ready=1, release reset -> after E1,E2,E3 id_instruction = 0x00021025, 0x00FF2025, 0x00000025 with id_pc = 0,4,8, id_pc_plus4 = 4,8,12.
- After first valid, id_ready=0 for 3 cycles -> id_instruction holds 0x00021025, pc holds 4; id_ready=1 -> next edge id_instruction=0x00FF2025, id_pc=4.
- Redirect_pc=0x8 while id_valid=1, id_ready=0 -> next edge id_valid=0, pc=8; following edge id_valid=1, id_pc=8, id_instruction=0x00000025.
- IMEM_BYTES=256, redirect to 0xFC -> word at 0xFC captured, pc=0x100; next load -> fault=1, fault_pc=0x100, id_valid=0; later redirect to 0x0 ignored, fault stays 1.
- Redirect to 0x6 -> next edge fault=1, fault_pc=0x6, id_valid=0, pc unchanged.
- Reset asserted while id_valid=1 at pc=0x10 (and separately while in FAULT) -> next edge pc=RESET_PC, id_valid=0, all id_* = 0, fault=0, fault_pc=0; resumes via BOOT.
